// File: rtl/kamacore_lsu_if.sv
// Bundle of EX-side, data-memory and WB/forwarding signals around the LSU.
// master = the LSU itself, slave = its environment (pipeline + memory).
interface kamacore_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RA_W   = 5
);
  logic              in_valid, in_ready, in_mem_re, in_mem_we;
  logic [2:0]        in_funct3;
  logic [ADDR_W-1:0] in_addr;
  logic [XLEN-1:0]   in_wdata;
  logic [RA_W-1:0]   in_rd;
  logic              in_rd_we;
  logic              dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [ADDR_W-1:0] dmem_addr;
  logic [XLEN/8-1:0] dmem_be;
  logic [XLEN-1:0]   dmem_wdata, dmem_rdata;
  logic              out_valid, out_rd_we;
  logic [RA_W-1:0]   out_rd;
  logic [XLEN-1:0]   out_result;
  logic [1:0]        out_fault;
  logic              fwd_we, fwd_pending;
  logic [RA_W-1:0]   fwd_a, fwd_pending_a;
  logic [XLEN-1:0]   fwd_data;

  modport master (
    input  in_valid, in_mem_re, in_mem_we, in_funct3, in_addr, in_wdata, in_rd, in_rd_we,
           dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    output in_ready, dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
           out_valid, out_rd, out_rd_we, out_result, out_fault,
           fwd_we, fwd_a, fwd_data, fwd_pending, fwd_pending_a
  );

  modport slave (
    output in_valid, in_mem_re, in_mem_we, in_funct3, in_addr, in_wdata, in_rd, in_rd_we,
           dmem_req_ready, dmem_rsp_valid, dmem_rdata,
    input  in_ready, dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
           out_valid, out_rd, out_rd_we, out_result, out_fault,
           fwd_we, fwd_a, fwd_data, fwd_pending, fwd_pending_a
  );
endinterface

// File: rtl/kamacore_lsu.sv
// Load/store unit: one op at a time, req/rsp data-memory port with
// backpressure, byte-lane steering, load extension, timeout abort.
module kamacore_lsu #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int RA_W    = 5,
  parameter int TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  kamacore_lsu_if.master bus
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              re_q, we_q, rd_we_q;
  logic [2:0]        f3_q;
  logic [OFFW-1:0]   off_q;
  logic [RA_W-1:0]   rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_q;
  logic [XLEN-1:0]   wdata_q;
  logic              ov_q, ov_d, orwe_q, orwe_d;
  logic [RA_W-1:0]   ord_q, ord_d;
  logic [XLEN-1:0]   ores_q, ores_d;
  logic [1:0]        of_q, of_d;
  logic              cap;

  logic              acc, illegal, misal, is_mem;
  logic [1:0]        sz;
  logic [OFFW-1:0]   in_off;
  logic [NB-1:0]     be_base;
  logic [XLEN-1:0]   wmask, lane, ld_ext;

  assign acc    = bus.in_valid & bus.in_ready;
  assign is_mem = bus.in_mem_re | bus.in_mem_we;
  assign sz     = bus.in_funct3[1:0];
  assign in_off = bus.in_addr[OFFW-1:0];

  // Decode legality and alignment of the offered operation.
  always_comb begin
    illegal = 1'b0;
    misal   = 1'b0;
    if (bus.in_mem_re & bus.in_mem_we) illegal = 1'b1;
    else if (bus.in_mem_re) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal = 1'b0;
        3'b011, 3'b110:                         illegal = (XLEN != 64);
        default:                                illegal = 1'b1;
      endcase
    end else if (bus.in_mem_we) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010: illegal = 1'b0;
        3'b011:                 illegal = (XLEN != 64);
        default:                illegal = 1'b1;
      endcase
    end
    case (sz)
      2'd1:    misal = bus.in_addr[0];
      2'd2:    misal = |bus.in_addr[1:0];
      2'd3:    misal = |bus.in_addr[2:0];
      default: misal = 1'b0;
    endcase
  end

  // Byte enables for the access size and a matching data mask.
  always_comb begin
    case (sz)
      2'd0:    be_base = NB'(1);
      2'd1:    be_base = NB'(3);
      2'd2:    be_base = NB'(15);
      default: be_base = '1;
    endcase
    wmask = '0;
    for (int i = 0; i < NB; i++) wmask[8*i +: 8] = {8{be_base[i]}};
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    lane = bus.dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = XLEN'($signed(lane[7:0]));
      3'b001:  ld_ext = XLEN'($signed(lane[15:0]));
      3'b010:  ld_ext = XLEN'($signed(lane[31:0]));
      3'b100:  ld_ext = XLEN'(lane[7:0]);
      3'b101:  ld_ext = XLEN'(lane[15:0]);
      3'b110:  ld_ext = XLEN'(lane[31:0]);
      default: ld_ext = lane;
    endcase
  end

  // Next state, timeout counter and next WB result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap     = 1'b0;
    ov_d    = 1'b0;
    ord_d   = ord_q;
    orwe_d  = orwe_q;
    ores_d  = ores_q;
    of_d    = of_q;
    case (state_q)
      IDLE: if (acc) begin
        ord_d = bus.in_rd;
        if (is_mem && (illegal || misal)) begin
          ov_d = 1'b1; orwe_d = 1'b0; ores_d = '0;
          of_d = illegal ? 2'b10 : 2'b01;
        end else if (is_mem) begin
          cap = 1'b1; state_d = REQ; cnt_d = '0;
        end else begin
          ov_d   = 1'b1;
          orwe_d = bus.in_rd_we & (|bus.in_rd);
          ores_d = XLEN'(bus.in_addr);
          of_d   = 2'b00;
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (state_q == REQ && bus.dmem_req_ready && we_q) begin
          state_d = IDLE; ov_d = 1'b1; ord_d = rd_q; orwe_d = 1'b0; ores_d = '0; of_d = 2'b00;
        end else if (state_q == WAIT && bus.dmem_rsp_valid) begin
          state_d = IDLE; ov_d = 1'b1; ord_d = rd_q; orwe_d = rd_we_q & (|rd_q);
          ores_d = ld_ext; of_d = 2'b00;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Also taken when a load is accepted on the last allowed cycle:
          // there is no budget left to wait for its data.
          state_d = IDLE; ov_d = 1'b1; ord_d = rd_q; orwe_d = 1'b0; ores_d = '0; of_d = 2'b11;
        end else if (state_q == REQ && bus.dmem_req_ready) begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured operation and WB result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE; cnt_q <= '0;
      re_q <= 1'b0; we_q <= 1'b0; rd_we_q <= 1'b0; f3_q <= '0; off_q <= '0; rd_q <= '0;
      addr_q <= '0; be_q <= '0; wdata_q <= '0;
      ov_q <= 1'b0; orwe_q <= 1'b0; ord_q <= '0; ores_q <= '0; of_q <= 2'b00;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d;
      ov_q <= ov_d; orwe_q <= orwe_d; ord_q <= ord_d; ores_q <= ores_d; of_q <= of_d;
      if (cap) begin
        re_q    <= bus.in_mem_re;
        we_q    <= bus.in_mem_we;
        rd_we_q <= bus.in_rd_we;
        f3_q    <= bus.in_funct3;
        off_q   <= in_off;
        rd_q    <= bus.in_rd;
        addr_q  <= bus.in_addr & ~ADDR_W'(NB - 1);
        be_q    <= be_base << in_off;
        wdata_q <= (bus.in_wdata & wmask) << {in_off, 3'b000};
      end
    end
  end

  assign bus.in_ready       = (state_q == IDLE) & ~rst;
  assign bus.dmem_req_valid = (state_q == REQ);
  assign bus.dmem_addr      = addr_q;
  assign bus.dmem_we        = (state_q == REQ) & we_q;
  assign bus.dmem_be        = (state_q == REQ) ? be_q : '0;
  assign bus.dmem_wdata     = wdata_q;
  assign bus.out_valid      = ov_q;
  assign bus.out_rd         = ord_q;
  assign bus.out_rd_we      = orwe_q;
  assign bus.out_result     = ores_q;
  assign bus.out_fault      = of_q;
  assign bus.fwd_we         = orwe_q & ov_q;
  assign bus.fwd_a          = ord_q;
  assign bus.fwd_data       = ores_q;
  assign bus.fwd_pending    = (state_q != IDLE) & re_q;
  assign bus.fwd_pending_a  = rd_q;
endmodule

// File: tb/tb_kamacore_lsu.sv
// Directed bench for kamacore_lsu (XLEN=32, TIMEOUT=4).
module tb_kamacore_lsu;
  logic clk, rst;
  int   pas = 0, tot = 0;

  kamacore_lsu_if #(.XLEN(32), .ADDR_W(32), .RA_W(5)) bus ();
  kamacore_lsu #(.XLEN(32), .ADDR_W(32), .RA_W(5), .TIMEOUT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    bus.in_valid = 0; bus.in_mem_re = 0; bus.in_mem_we = 0; bus.in_funct3 = 0;
    bus.in_addr = 0; bus.in_wdata = 0; bus.in_rd = 0; bus.in_rd_we = 0;
  endtask

  task automatic drive_op(input logic re, input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input logic rdwe);
    bus.in_valid = 1; bus.in_mem_re = re; bus.in_mem_we = we; bus.in_funct3 = f3;
    bus.in_addr = a; bus.in_wdata = wd; bus.in_rd = rd; bus.in_rd_we = rdwe;
  endtask

  task automatic test_reset();
    rst = 1; drive_idle();
    bus.dmem_req_ready = 0; bus.dmem_rsp_valid = 0; bus.dmem_rdata = 0;
    tick();
    tot++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b want 0", bus.in_ready); else pas++;
    tot++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); else pas++;
    tot++; if (bus.dmem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %0b want 0", bus.dmem_req_valid); else pas++;
    tot++; if (bus.dmem_be !== 4'h0) $display("FAIL rst_be: got %0h want 0", bus.dmem_be); else pas++;
    tot++; if (bus.out_result !== 32'h0 || bus.out_fault !== 2'b00) $display("FAIL rst_result: got %0h/%0b want 0/0", bus.out_result, bus.out_fault); else pas++;
    tot++; if (bus.fwd_pending !== 1'b0) $display("FAIL rst_pending: got %0b want 0", bus.fwd_pending); else pas++;
    rst = 0; #1;
    tot++; if (bus.in_ready !== 1'b1) $display("FAIL rst_release_ready: got %0b want 1", bus.in_ready); else pas++;
  endtask

  task automatic test_passthrough();
    drive_op(0, 0, 3'b000, 32'h1234, 32'h0, 5'd5, 1);
    tick();
    tot++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h1234) $display("FAIL pt1: got v=%0b r=%0h want 1/1234", bus.out_valid, bus.out_result); else pas++;
    tot++; if (bus.fwd_we !== 1'b1 || bus.fwd_a !== 5'd5 || bus.fwd_data !== 32'h1234) $display("FAIL pt1_fwd: got %0b/%0d/%0h want 1/5/1234", bus.fwd_we, bus.fwd_a, bus.fwd_data); else pas++;
    tot++; if (bus.in_ready !== 1'b1) $display("FAIL pt1_ready: got %0b want 1", bus.in_ready); else pas++;
    drive_op(0, 0, 3'b111, 32'h1234, 32'h0, 5'd6, 1);
    tick();
    tot++; if (bus.out_valid !== 1'b1 || bus.out_rd !== 5'd6 || bus.out_result !== 32'h1234 || bus.out_fault !== 2'b00) $display("FAIL pt2: got v=%0b rd=%0d r=%0h f=%0b want 1/6/1234/0", bus.out_valid, bus.out_rd, bus.out_result, bus.out_fault); else pas++;
    drive_op(0, 0, 3'b000, 32'hCAFE, 32'h0, 5'd0, 1);
    tick();
    tot++; if (bus.out_rd_we !== 1'b0 || bus.fwd_we !== 1'b0 || bus.out_result !== 32'hCAFE) $display("FAIL pt_rd0: got we=%0b fwd=%0b r=%0h want 0/0/cafe", bus.out_rd_we, bus.fwd_we, bus.out_result); else pas++;
    drive_idle();
    tick();
    tot++; if (bus.out_valid !== 1'b0 || bus.out_result !== 32'hCAFE) $display("FAIL pt_hold: got v=%0b r=%0h want 0/cafe", bus.out_valid, bus.out_result); else pas++;
  endtask

  task automatic test_store();
    drive_op(0, 1, 3'b000, 32'h1003, 32'hAB, 5'd0, 0);
    bus.dmem_req_ready = 0;
    tick();
    bus.in_valid = 0; bus.in_addr = 32'hFFFF_FFFF; bus.in_wdata = 32'h1111_1111;
    for (int i = 0; i < 3; i++) begin
      tot++; if (bus.dmem_req_valid !== 1'b1 || bus.dmem_addr !== 32'h1000 || bus.dmem_be !== 4'b1000 || bus.dmem_wdata !== 32'hAB00_0000 || bus.dmem_we !== 1'b1)
        $display("FAIL sb_req%0d: got v=%0b a=%0h be=%0b wd=%0h we=%0b want 1/1000/1000/ab000000/1", i, bus.dmem_req_valid, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, bus.dmem_we); else pas++;
      tot++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) $display("FAIL sb_stall%0d: got rdy=%0b v=%0b want 0/0", i, bus.in_ready, bus.out_valid); else pas++;
      tick();
    end
    bus.dmem_req_ready = 1;
    tot++; if (bus.dmem_req_valid !== 1'b1 || bus.dmem_be !== 4'b1000) $display("FAIL sb_req3: got v=%0b be=%0b want 1/1000", bus.dmem_req_valid, bus.dmem_be); else pas++;
    tick();
    bus.dmem_req_ready = 0;
    tot++; if (bus.out_valid !== 1'b1 || bus.out_rd_we !== 1'b0 || bus.out_fault !== 2'b00) $display("FAIL sb_done: got v=%0b we=%0b f=%0b want 1/0/0", bus.out_valid, bus.out_rd_we, bus.out_fault); else pas++;
    tot++; if (bus.dmem_req_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL sb_idle: got v=%0b rdy=%0b want 0/1", bus.dmem_req_valid, bus.in_ready); else pas++;
    // halfword store, immediate ready, upper wdata bits must be masked off
    drive_op(0, 1, 3'b001, 32'h1002, 32'h1234_BEEF, 5'd3, 1);
    bus.dmem_req_ready = 1;
    tick();
    drive_idle();
    tot++; if (bus.dmem_be !== 4'b1100 || bus.dmem_wdata !== 32'hBEEF_0000 || bus.dmem_addr !== 32'h1000) $display("FAIL sh_lane: got be=%0b wd=%0h a=%0h want 1100/beef0000/1000", bus.dmem_be, bus.dmem_wdata, bus.dmem_addr); else pas++;
    tick();
    bus.dmem_req_ready = 0;
    tot++; if (bus.out_valid !== 1'b1 || bus.out_rd_we !== 1'b0) $display("FAIL sh_done: got v=%0b we=%0b want 1/0", bus.out_valid, bus.out_rd_we); else pas++;
    tick();
  endtask

  task automatic test_load(input logic [2:0] f3, input logic [31:0] exp, input string nm);
    drive_op(1, 0, f3, 32'h2002, 32'h0, 5'd7, 1);
    bus.dmem_req_ready = 1;
    tick();
    drive_idle();
    bus.dmem_rsp_valid = 1; bus.dmem_rdata = 32'hDEAD_BEEF;  // same-cycle rsp must be ignored
    tot++; if (bus.dmem_req_valid !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_be !== 4'b0100 || bus.dmem_addr !== 32'h2000) $display("FAIL %s_req: got v=%0b we=%0b be=%0b a=%0h want 1/0/0100/2000", nm, bus.dmem_req_valid, bus.dmem_we, bus.dmem_be, bus.dmem_addr); else pas++;
    tot++; if (bus.fwd_pending !== 1'b1 || bus.fwd_pending_a !== 5'd7) $display("FAIL %s_pend_req: got %0b/%0d want 1/7", nm, bus.fwd_pending, bus.fwd_pending_a); else pas++;
    tick();
    bus.dmem_req_ready = 0;
    bus.dmem_rsp_valid = 1; bus.dmem_rdata = 32'h0080_0000;
    tot++; if (bus.fwd_pending !== 1'b1 || bus.out_valid !== 1'b0 || bus.dmem_req_valid !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL %s_wait: got p=%0b v=%0b rq=%0b rdy=%0b want 1/0/0/0", nm, bus.fwd_pending, bus.out_valid, bus.dmem_req_valid, bus.in_ready); else pas++;
    tick();
    bus.dmem_rsp_valid = 0;
    tot++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp || bus.out_rd !== 5'd7 || bus.out_rd_we !== 1'b1) $display("FAIL %s_data: got v=%0b r=%0h rd=%0d we=%0b want 1/%0h/7/1", nm, bus.out_valid, bus.out_result, bus.out_rd, bus.out_rd_we, exp); else pas++;
    tot++; if (bus.fwd_pending !== 1'b0 || bus.in_ready !== 1'b1 || bus.fwd_we !== 1'b1) $display("FAIL %s_end: got p=%0b rdy=%0b fwd=%0b want 0/1/1", nm, bus.fwd_pending, bus.in_ready, bus.fwd_we); else pas++;
    tick();
  endtask

  task automatic test_faults();
    drive_op(1, 0, 3'b001, 32'h3001, 32'h0, 5'd8, 1);
    tick();
    tot++; if (bus.out_valid !== 1'b1 || bus.out_fault !== 2'b01 || bus.out_rd_we !== 1'b0 || bus.out_result !== 32'h0 || bus.dmem_req_valid !== 1'b0) $display("FAIL misal: got v=%0b f=%0b we=%0b r=%0h rq=%0b want 1/01/0/0/0", bus.out_valid, bus.out_fault, bus.out_rd_we, bus.out_result, bus.dmem_req_valid); else pas++;
    drive_op(1, 0, 3'b111, 32'h3000, 32'h0, 5'd8, 1);
    tick();
    tot++; if (bus.out_valid !== 1'b1 || bus.out_fault !== 2'b10 || bus.dmem_req_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL ill_f3: got v=%0b f=%0b rq=%0b rdy=%0b want 1/10/0/1", bus.out_valid, bus.out_fault, bus.dmem_req_valid, bus.in_ready); else pas++;
    drive_op(1, 1, 3'b010, 32'h3000, 32'h0, 5'd8, 1);
    tick();
    tot++; if (bus.out_valid !== 1'b1 || bus.out_fault !== 2'b10 || bus.dmem_req_valid !== 1'b0) $display("FAIL ill_rewe: got v=%0b f=%0b rq=%0b want 1/10/0", bus.out_valid, bus.out_fault, bus.dmem_req_valid); else pas++;
    drive_op(0, 1, 3'b011, 32'h3000, 32'h0, 5'd8, 0);
    tick();
    drive_idle();
    tot++; if (bus.out_fault !== 2'b10 || bus.dmem_req_valid !== 1'b0) $display("FAIL ill_sd32: got f=%0b rq=%0b want 10/0", bus.out_fault, bus.dmem_req_valid); else pas++;
    tick();
  endtask

  task automatic test_timeout();
    drive_op(1, 0, 3'b010, 32'h4000, 32'h0, 5'd9, 1);
    bus.dmem_req_ready = 1;
    tick();
    drive_idle();
    tick();
    bus.dmem_req_ready = 0;
    tick(); tick();
    tot++; if (bus.out_valid !== 1'b0 || bus.fwd_pending !== 1'b1) $display("FAIL to_ld_wait: got v=%0b p=%0b want 0/1", bus.out_valid, bus.fwd_pending); else pas++;
    tick();
    bus.dmem_rsp_valid = 1; bus.dmem_rdata = 32'h55;
    tot++; if (bus.out_valid !== 1'b1 || bus.out_fault !== 2'b11 || bus.out_rd_we !== 1'b0 || bus.in_ready !== 1'b1 || bus.fwd_pending !== 1'b0) $display("FAIL to_ld: got v=%0b f=%0b we=%0b rdy=%0b p=%0b want 1/11/0/1/0", bus.out_valid, bus.out_fault, bus.out_rd_we, bus.in_ready, bus.fwd_pending); else pas++;
    tick();
    bus.dmem_rsp_valid = 0;
    tot++; if (bus.out_valid !== 1'b0 || bus.out_fault !== 2'b11 || bus.out_result !== 32'h0) $display("FAIL to_late_rsp: got v=%0b f=%0b r=%0h want 0/11/0", bus.out_valid, bus.out_fault, bus.out_result); else pas++;
    // store stuck in REQ: request must drop when the budget runs out
    drive_op(0, 1, 3'b010, 32'h4004, 32'h77, 5'd0, 0);
    tick();
    drive_idle();
    tick(); tick(); tick();
    tot++; if (bus.dmem_req_valid !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL to_st_last: got rq=%0b v=%0b want 1/0", bus.dmem_req_valid, bus.out_valid); else pas++;
    tick();
    tot++; if (bus.dmem_req_valid !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_fault !== 2'b11) $display("FAIL to_st: got rq=%0b v=%0b f=%0b want 0/1/11", bus.dmem_req_valid, bus.out_valid, bus.out_fault); else pas++;
    tick();
  endtask

  task automatic test_reset_mid();
    drive_op(1, 0, 3'b010, 32'h0, 32'h0, 5'd10, 1);
    bus.dmem_req_ready = 1;
    tick();
    drive_idle();
    tick();
    bus.dmem_req_ready = 0;
    tot++; if (bus.fwd_pending !== 1'b1) $display("FAIL rm_pend: got %0b want 1", bus.fwd_pending); else pas++;
    rst = 1; #1;
    tot++; if (bus.in_ready !== 1'b0 || bus.dmem_req_valid !== 1'b0 || bus.fwd_pending !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_fault !== 2'b00 || bus.out_rd !== 5'd0)
      $display("FAIL rm_async: got rdy=%0b rq=%0b p=%0b v=%0b f=%0b rd=%0d want 0/0/0/0/0/0", bus.in_ready, bus.dmem_req_valid, bus.fwd_pending, bus.out_valid, bus.out_fault, bus.out_rd); else pas++;
    tick();
    rst = 0;
    bus.dmem_rsp_valid = 1; bus.dmem_rdata = 32'h1234_5678;  // stale rsp after reset must not produce a result
    tick();
    bus.dmem_rsp_valid = 0;
    tot++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL rm_release: got rdy=%0b v=%0b want 1/0", bus.in_ready, bus.out_valid); else pas++;
    drive_op(1, 0, 3'b010, 32'h0, 32'h0, 5'd11, 1);
    bus.dmem_req_ready = 1;
    tick();
    drive_idle();
    tick();
    bus.dmem_req_ready = 0;
    bus.dmem_rsp_valid = 1; bus.dmem_rdata = 32'h89AB_CDEF;
    tick();
    bus.dmem_rsp_valid = 0;
    tot++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h89AB_CDEF || bus.out_rd !== 5'd11 || bus.out_rd_we !== 1'b1) $display("FAIL rm_lw: got v=%0b r=%0h rd=%0d we=%0b want 1/89abcdef/11/1", bus.out_valid, bus.out_result, bus.out_rd, bus.out_rd_we); else pas++;
    tick();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_store();
    test_load(3'b000, 32'hFFFF_FF80, "lb");
    test_load(3'b100, 32'h0000_0080, "lbu");
    test_faults();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pas, tot);
    $finish;
  end
endmodule

// File: doc/kamacore_lsu.md
# kamacore_lsu

Parametrised load/store unit replacing the single-cycle memory stage between EX and WB. It accepts one memory or pass-through operation at a time and drives a request/response data-memory port with backpressure. Byte/half/word (and doubleword when XLEN=64) accesses use byte enables, and loads are sign- or zero-extended. It stalls upstream while an access is outstanding, aborts hung accesses on a timeout, and exports forwarding and load-pending information to the hazard logic.

## Interface
- XLEN, 32, data width; 32 or 64 only
- ADDR_W, 32, byte-address width
- RA_W, 5, register-index width
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before abort; ≥2
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operation offered by EX
- in_ready  out  1  LSU accepts (state IDLE and rst low)
- in_mem_re / in_mem_we  in  1 each  load / store; both high is illegal
- in_funct3  in  3  access size/sign (RISC-V encoding)
- in_addr  in  ADDR_W  byte address (ALU result)
- in_wdata  in  XLEN  store data (source2)
- in_rd  in  RA_W  destination register
- in_rd_we  in  1  writeback enable
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  ADDR_W  in_addr with low log2(XLEN/8) bits cleared
- dmem_we  out  1  store
- dmem_be  out  XLEN/8  byte enables
- dmem_wdata  out  XLEN  store data shifted to lane
- dmem_rsp_valid  in  1  load data valid
- dmem_rdata  in  XLEN  load data, full word
- out_valid  out  1  one-cycle pulse: result to WB
- out_rd  out  RA_W  destination
- out_rd_we  out  1  writeback enable
- out_result  out  XLEN  extended load data or pass-through in_addr
- out_fault  out  2  00 ok, 01 misaligned, 10 illegal funct3/op, 11 timeout
- fwd_we, fwd_a, fwd_data  out  1/RA_W/XLEN  = out_rd_we&out_valid, out_rd, out_result
- fwd_pending, fwd_pending_a  out  1/RA_W  load outstanding, its rd

## Operation
- States IDLE, REQ, WAIT. Accept on in_valid & in_ready; all inputs captured, so upstream may change them afterwards.
- Non-memory accept (re=we=0): next cycle out_valid=1, out_result=in_addr, rd/rd_we passed; stay IDLE.
- funct3 legality: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000/001/010; XLEN=64 adds 011 LD/SD and 110 LWU. Anything else, or re&we, -> out_fault=10.
- Alignment: half needs addr[0]=0, word addr[1:0]=0, double addr[2:0]=0; else out_fault=01.
- Faulted ops issue no request: next cycle out_valid=1, out_rd_we=0, out_result=0; stay IDLE.
- Legal mem op -> REQ: dmem_req_valid=1 with addr/we/be/wdata stable until dmem_req_ready.
  - Store accepted -> IDLE; next cycle out_valid=1, out_rd_we=0.
  - Load accepted -> WAIT.
- WAIT: on dmem_rsp_valid, select lane by addr offset, sign- or zero-extend to XLEN; next cycle out_valid=1 with that data, out_rd_we=captured rd_we; -> IDLE.
- dmem_rsp_valid outside WAIT is ignored. A response in the same cycle as request acceptance is not legal from memory and is ignored.
- Timeout: a counter clears on entering REQ and increments each REQ/WAIT cycle. Reaching TIMEOUT -> IDLE; next cycle out_valid=1, out_fault=11, out_rd_we=0; dmem_req_valid drops immediately.
- out_rd_we is forced 0 whenever out_rd=0.
- fwd_pending=1 in REQ/WAIT for loads only; fwd_pending_a=captured rd.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, out_valid=0, out_rd=0, out_rd_we=0, out_result=0, out_fault=00, dmem_req_valid=0, dmem_we=0, dmem_be=0, fwd_pending=0, in_ready=0 while rst is high.
- Reset mid-access drops the request that cycle and produces no result.
- Latency from accept edge to out_valid:
  - Non-mem or fault: 1 cycle.
  - Store: 1 + cycles until req_ready (minimum 2).
  - Load: request cycle(s) + ≥1 WAIT cycle + 1 (minimum 3).
- Throughput: pass-through ops can be accepted back-to-back, one per cycle. in_ready is low in REQ/WAIT and returns high the cycle out_valid rises.
- out_* registers hold until the next result; out_valid is a single-cycle pulse.

## Test plan
- Pass-through: in_addr=0x1234, rd=5, rd_we=1 on two consecutive cycles -> out_valid on two consecutive cycles, out_result=0x1234, fwd_we=1, fwd_a=5.
- SB: addr=0x1003, wdata=0xAB, req_ready held low 3 cycles -> dmem_addr=0x1000, be=1000, wdata=0xAB000000, all stable until ready; out_valid 1 cycle after ready, rd_we=0.
- LB vs LBU: addr=0x2002, rdata=0x00800000, rsp 2 cycles after accept -> LB result 0xFFFFFF80, LBU 0x00000080; fwd_pending=1 with rd until out_valid.
- LH at addr=0x3001 -> no dmem request, out_fault=01, out_rd_we=0, latency 1; funct3=111 load -> out_fault=10.
- Timeout with TIMEOUT=4: load accepted, rsp never arrives -> req_valid low and out_fault=11 at the expected cycle; a late rsp_valid in IDLE is ignored.
- rst pulsed while in WAIT -> outputs at reset values, in_ready=1 the cycle after release, next LW at 0x0 returns rdata unchanged.
